mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have a single clock: clk  in  1  rising-edge clock for all state.
REQ-002 The block SHALL have one reset: rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-003 The block SHALL have these inputs from the execute stage:
- ex_mem_alu_result  in  32  address / ALU result.
- ex_mem_rs2_data  in  32  store data.
- ex_mem_pc_4  in  32  link value.
- ex_mem_rd  in  5  destination register.
- ex_mem_funct3  in  3  access size/sign.
- ex_mem_mem_read_en, ex_mem_mem_write_en, ex_mem_reg_write_en  in  1 each.
- ex_mem_mem_to_reg_sel  in  2  0=ALU, 1=load, 2=PC+4.
REQ-004 The block SHALL have this data-memory port:
- dmem_req  out  1.
- dmem_we  out  1.
- dmem_addr  out  32  word-aligned.
- dmem_wdata  out  32.
- dmem_be  out  4.
- dmem_ready  in  1  access complete; read data valid this cycle.
- dmem_rdata  in  32.
REQ-005 The block SHALL have these outputs:
- mem_wb_rd  out  5.
- mem_wb_reg_write_en  out  1.
- mem_wb_write_data  out  32.
- mem_stall  out  1  freeze all upstream stages.
- misalign_err  out  1  one-cycle pulse.
- stall_count  out  32  cumulative stall cycles.

Function
REQ-010 FSM states SHALL be IDLE and WAIT.
REQ-011 Access condition: access = (ex_mem_mem_read_en | ex_mem_mem_write_en) & aligned.
- Aligned rules: word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned.
REQ-012 In IDLE with access, dmem_req SHALL be 1 combinationally.
- If dmem_ready=0 in that cycle: go to WAIT.
- If dmem_ready=1 in that cycle: complete in the same cycle (zero-wait).
REQ-013 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL stay stable until dmem_ready=1; then return to IDLE.
REQ-014 mem_stall SHALL equal dmem_req & ~dmem_ready.
- Upstream holds the ex_mem_* inputs constant while mem_stall=1.
REQ-015 Memory address and write enable:
- dmem_addr = {alu_result[31:2], 2'b00}.
- dmem_we = ex_mem_mem_write_en.
REQ-016 Store byte enables and write data:
- SB: dmem_be = 0001 << addr[1:0]; dmem_wdata = byte replicated 4 times.
- SH: dmem_be = 0011 << addr[1:0]; dmem_wdata = halfword replicated 2 times.
- SW: dmem_be = 1111; dmem_wdata = rs2 data unmodified.
- Reads: dmem_be = 1111.
REQ-017 Load extraction SHALL select the byte/half at offset addr[1:0] from dmem_rdata, by funct3:
- 000 LB: sign-extend byte.
- 001 LH: sign-extend half.
- 010 LW: full word.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend half.
- Any other funct3: full word.
REQ-018 Writeback data mux by mem_to_reg_sel:
- 0: ex_mem_alu_result.
- 1: extracted load data.
- 2: ex_mem_pc_4.
- 3: 0.
REQ-019 The mem_wb_* registers SHALL update on every clk edge with mem_stall=0, one-cycle latency.
- On any edge with mem_stall=1: mem_wb_reg_write_en <= 0 (bubble).
- On such an edge, mem_wb_rd and mem_wb_write_data SHALL hold their values.
REQ-020 Misaligned access (read or write enable set but not aligned):
- No dmem_req.
- mem_wb_reg_write_en <= 0.
- misalign_err <= 1 for exactly one cycle.
- No stall.
REQ-021 Non-memory instructions SHALL pass through with no request and no stall.
REQ-022 stall_count SHALL increment by 1 each cycle mem_stall=1, wrapping 32'hFFFFFFFF to 0.

Reset
REQ-030 rst=0 SHALL asynchronously force:
- FSM to IDLE.
- All mem_wb_* outputs, misalign_err and stall_count to 0.
- dmem_req to 0 regardless of inputs.
REQ-031 Reset asserted while in WAIT SHALL abandon the access.
- A late dmem_ready after reset release SHALL be ignored while in IDLE with no access.

Structure
REQ-040 Opcode constants, funct3 load/store encodings and the mem_to_reg_sel encodings SHALL live in the shared core package.
REQ-041 Load extraction SHALL be a combinational sub-module named load_align.

Verification
REQ-050 LW, addr 0x100, rdata 0xDEADBEEF, zero-wait ready:
- mem_stall stays 0.
- Next cycle: mem_wb_write_data=0xDEADBEEF, reg_write_en=1.
REQ-051 LB, addr 0x103, rdata 0x80112233, ready after 3 cycles:
- mem_stall=1 for 3 cycles.
- During stall: mem_wb_reg_write_en=0.
- Then: write_data=0xFFFFFF80.
- stall_count=3.
REQ-052 SH, addr 0x202, rs2=0x0000ABCD:
- dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- mem_wb_reg_write_en=0.
REQ-053 LW at addr 0x101:
- No dmem_req.
- misalign_err pulses once.
- mem_wb_reg_write_en=0.
REQ-054 JAL, pc_4=0x2004, sel=2:
- No request.
- mem_wb_write_data=0x2004.
REQ-055 rst=0 asserted during WAIT:
- dmem_req=0 immediately.
- All outputs 0.
- After release, FSM in IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared core encodings for the memory stage
package mem_stage_pkg;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_PC4  = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    // Size comes from funct3[1:0]; unsigned loads share the signed sizes.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b00) ? 1'b1 : (f3[1:0] == 2'b01) ? ~off[0] : (off == 2'b00);
    endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: pick and extend the addressed byte/half from a read word
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    // Shift the addressed lane down, then extend according to funct3.
    always_comb begin
        b    = 8'(rdata >> {offset, 3'd0});
        h    = 16'(rdata >> {offset[1], 4'd0});
        data = (funct3 == F3_B)  ? {{24{b[7]}}, b} :
               (funct3 == F3_H)  ? {{16{h[15]}}, h} :
               (funct3 == F3_BU) ? {24'd0, b} :
               (funct3 == F3_HU) ? {16'd0, h} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access, load alignment and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rs2_data,
    input  logic [31:0] ex_mem_pc_4,
    input  logic [4:0]  ex_mem_rd,
    input  logic [2:0]  ex_mem_funct3,
    input  logic        ex_mem_mem_read_en,
    input  logic        ex_mem_mem_write_en,
    input  logic        ex_mem_reg_write_en,
    input  logic [1:0]  ex_mem_mem_to_reg_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_write_en,
    output logic [31:0] mem_wb_write_data,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic [31:0] stall_count
);
    mem_state_t  state, state_nxt;
    logic [1:0]  off;
    logic        mem_en, aligned, access, misalign;
    logic [31:0] load_data, wb_data;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (off),
        .funct3 (ex_mem_funct3),
        .data   (load_data)
    );

    // Request, store lane formatting and writeback selection.
    always_comb begin
        off        = ex_mem_alu_result[1:0];
        mem_en     = ex_mem_mem_read_en | ex_mem_mem_write_en;
        aligned    = is_aligned(ex_mem_funct3, off);
        access     = mem_en & aligned;
        misalign   = mem_en & ~aligned;
        dmem_req   = rst & access;
        mem_stall  = dmem_req & ~dmem_ready;
        dmem_we    = ex_mem_mem_write_en;
        dmem_addr  = {ex_mem_alu_result[31:2], 2'b00};
        dmem_wdata = (ex_mem_funct3[1:0] == 2'b00) ? {4{ex_mem_rs2_data[7:0]}} :
                     (ex_mem_funct3[1:0] == 2'b01) ? {2{ex_mem_rs2_data[15:0]}} : ex_mem_rs2_data;
        dmem_be    = ~ex_mem_mem_write_en ? 4'b1111 :
                     (ex_mem_funct3[1:0] == 2'b00) ? 4'b0001 << off :
                     (ex_mem_funct3[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
        wb_data    = (ex_mem_mem_to_reg_sel == SEL_ALU)  ? ex_mem_alu_result :
                     (ex_mem_mem_to_reg_sel == SEL_LOAD) ? load_data :
                     (ex_mem_mem_to_reg_sel == SEL_PC4)  ? ex_mem_pc_4 : 32'd0;
    end

    // Next state: stay in WAIT until memory acknowledges.
    always_comb begin
        state_nxt = state;
        if (state == IDLE && access && !dmem_ready)
            state_nxt = WAIT;
        else if (state == WAIT && dmem_ready)
            state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // MEM/WB register: bubble on stall, drop writeback on misaligned access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_rd           <= '0;
            mem_wb_reg_write_en <= 1'b0;
            mem_wb_write_data   <= '0;
            misalign_err        <= 1'b0;
            stall_count         <= '0;
        end else begin
            misalign_err        <= misalign;
            stall_count         <= stall_count + {31'd0, mem_stall};
            mem_wb_reg_write_en <= ex_mem_reg_write_en & ~misalign & ~mem_stall;
            if (!mem_stall) begin
                mem_wb_rd         <= ex_mem_rd;
                mem_wb_write_data <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu = '0, rs2 = '0, pc4 = '0, rdata = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  f3 = '0;
    logic        re = 1'b0, we = 1'b0, rwe = 1'b0, ready = 1'b0;
    logic [1:0]  sel = '0;
    logic        dmem_req, dmem_we, mem_wb_reg_write_en, mem_stall, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, mem_wb_write_data, stall_count;
    logic [3:0]  dmem_be;
    logic [4:0]  mem_wb_rd;
    int          n_cmp = 0, n_bad = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_mem_alu_result(alu), .ex_mem_rs2_data(rs2), .ex_mem_pc_4(pc4),
        .ex_mem_rd(rd), .ex_mem_funct3(f3),
        .ex_mem_mem_read_en(re), .ex_mem_mem_write_en(we),
        .ex_mem_reg_write_en(rwe), .ex_mem_mem_to_reg_sel(sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(ready), .dmem_rdata(rdata),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write_en(mem_wb_reg_write_en),
        .mem_wb_write_data(mem_wb_write_data), .mem_stall(mem_stall),
        .misalign_err(misalign_err), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] dst, input logic rw, input logic [1:0] s);
        re = r; we = w; f3 = fn; alu = a; rs2 = d; rd = dst; rwe = rw; sel = s;
        #1;
    endtask

    initial begin
        #12;
        check("rst_req", {31'd0, dmem_req}, 0);
        check("rst_wb_we", {31'd0, mem_wb_reg_write_en}, 0);
        check("rst_wb_data", mem_wb_write_data, 0);
        check("rst_stall_count", stall_count, 0);
        tick();
        rst = 1'b1;

        drive(1, 0, 3'b010, 32'h100, 0, 5, 1, 2'd1);
        ready = 1; rdata = 32'hDEADBEEF; #1;
        check("lw_req", {31'd0, dmem_req}, 1);
        check("lw_stall", {31'd0, mem_stall}, 0);
        check("lw_addr", dmem_addr, 32'h100);
        check("lw_be", {28'd0, dmem_be}, 4'hF);
        tick();
        check("lw_data", mem_wb_write_data, 32'hDEADBEEF);
        check("lw_we", {31'd0, mem_wb_reg_write_en}, 1);
        check("lw_rd", {27'd0, mem_wb_rd}, 5);

        drive(1, 0, 3'b000, 32'h103, 0, 7, 1, 2'd1);
        ready = 0; rdata = 32'h80112233; #1;
        for (int i = 0; i < 3; i++) begin
            check("lb_stall", {31'd0, mem_stall}, 1);
            check("lb_addr", dmem_addr, 32'h100);
            tick();
            check("lb_bubble", {31'd0, mem_wb_reg_write_en}, 0);
        end
        check("lb_stall_count", stall_count, 3);
        check("lb_hold_data", mem_wb_write_data, 32'hDEADBEEF);
        ready = 1; #1;
        check("lb_release", {31'd0, mem_stall}, 0);
        tick();
        check("lb_data", mem_wb_write_data, 32'hFFFFFF80);
        check("lb_we", {31'd0, mem_wb_reg_write_en}, 1);
        check("lb_stall_count_after", stall_count, 3);

        drive(1, 0, 3'b001, 32'h102, 0, 8, 1, 2'd1);
        tick();
        check("lh_data", mem_wb_write_data, 32'hFFFF8011);
        drive(1, 0, 3'b101, 32'h102, 0, 8, 1, 2'd1);
        tick();
        check("lhu_data", mem_wb_write_data, 32'h00008011);

        drive(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, 2'd0);
        check("sh_be", {28'd0, dmem_be}, 4'b1100);
        check("sh_wdata", dmem_wdata, 32'hABCDABCD);
        check("sh_we", {31'd0, dmem_we}, 1);
        check("sh_addr", dmem_addr, 32'h200);
        tick();
        check("sh_wb_we", {31'd0, mem_wb_reg_write_en}, 0);

        drive(0, 1, 3'b000, 32'h201, 32'h12345677, 0, 0, 2'd0);
        check("sb_be", {28'd0, dmem_be}, 4'b0010);
        check("sb_wdata", dmem_wdata, 32'h77777777);
        tick();

        drive(1, 0, 3'b010, 32'h101, 0, 9, 1, 2'd1);
        check("mis_req", {31'd0, dmem_req}, 0);
        check("mis_stall", {31'd0, mem_stall}, 0);
        tick();
        check("mis_err", {31'd0, misalign_err}, 1);
        check("mis_wb_we", {31'd0, mem_wb_reg_write_en}, 0);
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 2'd0);
        tick();
        check("mis_err_pulse", {31'd0, misalign_err}, 0);

        pc4 = 32'h2004;
        drive(0, 0, 3'b000, 32'h55, 0, 1, 1, 2'd2);
        check("jal_req", {31'd0, dmem_req}, 0);
        tick();
        check("jal_data", mem_wb_write_data, 32'h2004);
        check("jal_we", {31'd0, mem_wb_reg_write_en}, 1);

        drive(1, 0, 3'b010, 32'h300, 0, 3, 1, 2'd1);
        ready = 0; #1;
        tick();
        check("wait_stall_count", stall_count, 4);
        rst = 0; #1;
        check("rstw_req", {31'd0, dmem_req}, 0);
        check("rstw_stall", {31'd0, mem_stall}, 0);
        check("rstw_count", stall_count, 0);
        check("rstw_wb_data", mem_wb_write_data, 0);
        check("rstw_wb_rd", {27'd0, mem_wb_rd}, 0);
        check("rstw_wb_we", {31'd0, mem_wb_reg_write_en}, 0);
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 2'd0);
        ready = 1;
        rst = 1; #1;
        tick();
        check("late_ready_req", {31'd0, dmem_req}, 0);
        check("late_ready_count", stall_count, 0);
        check("late_ready_we", {31'd0, mem_wb_reg_write_en}, 0);
        drive(1, 0, 3'b010, 32'h400, 0, 4, 1, 2'd1);
        rdata = 32'h0BADF00D; #1;
        check("idle_zero_wait", {31'd0, mem_stall}, 0);
        tick();
        check("idle_data", mem_wb_write_data, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
